// File: rtl/exc_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
//   Shared definitions for the exception sequencer:
//     - CP0 cause codes driven on ex_type (EXC_INT, EXC_SYS, EXC_BP, EXC_TR)
//     - sequencer state enum (IDLE, ENTER, HANDLER, RETURN)
//     - IRQ_ID_W, width of the serviced-IRQ index
//     - lowest_set(), index of the least-significant set bit of an 8-bit vector
// -----------------------------------------------------------------------------
package exc_pkg;

    localparam int IRQ_ID_W = 3;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_TR  = 5'd13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } exc_state_e;

    // Lowest set index wins; returns 0 for an all-zero vector, so callers
    // must qualify the result with a reduction-OR of the same vector.
    function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [7:0] v);
        lowest_set = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = IRQ_ID_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
//   One external interrupt line: a SYNC_STAGES-deep flop synchronizer followed
//   by a rising-edge detector on the synchronized level.
//
//   Ports:
//     clk        in   system clock, posedge
//     rst_n      in   asynchronous active-low reset, clears every flop
//     irq_async  in   raw asynchronous interrupt level
//     rise       out  one-cycle pulse when the synchronized level goes 0->1
//                     (combinational from flops, so it is glitch-free)
// -----------------------------------------------------------------------------
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_async};
            level_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~level_q;

endmodule

// File: rtl/exception_unit.sv
// -----------------------------------------------------------------------------
// exception_unit
//   Exception/interrupt sequencer in front of the CP0 register file. Collects
//   SYSCALL/BREAK/TEQ-trap/ERET from decode plus external IRQ lines, picks one
//   event, and drives CP0 with registered one-cycle strobes and a pipeline flush.
//
//   Parameters:
//     IRQ_W        number of external interrupt lines (1..8)
//     SYNC_STAGES  synchronizer depth per IRQ line (>= 2)
//
//   Ports:
//     clk, rst_n   clock (posedge) and asynchronous active-low reset
//     pc_i         PC of the instruction in decode
//     syscall_i, break_i, trap_i, eret_i   decoded events
//     status_ie, status_im                 CP0 Status.IE and interrupt mask
//     irq_i        asynchronous level-high interrupt lines
//     exception    CP0 strobe (entry and return)
//     eret         qualifies exception as a return
//     ex_type      cause code, updated on entry, held otherwise
//     epc          PC handed to CP0 (pc_i for sync events, pc_i+4 for IRQs)
//     flush        squash fetch/decode and take CP0's redirect
//     in_handler   handler is running
//     irq_id       index of the last serviced IRQ
//     fault_err    sticky: ERET outside a handler, or a sync event inside one
//     dbg_state    current sequencer state, for observation only
//
//   Optional build macro EXC_STATS_EN adds saturating counters:
//     exc_count    every entry
//     irq_count    interrupt entries only
//
//   Event interface: all event inputs are single-cycle level samples taken on
//   the rising clock edge; there is no ready/back-pressure, an event that
//   arrives while the sequencer cannot accept it is either flagged (fault_err)
//   or ignored (during the one-cycle ENTER/RETURN strobes).
// -----------------------------------------------------------------------------
module exception_unit
    import exc_pkg::*;
#(
    parameter int IRQ_W       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         pc_i,
    input  logic                syscall_i,
    input  logic                break_i,
    input  logic                trap_i,
    input  logic                eret_i,
    input  logic                status_ie,
    input  logic [IRQ_W-1:0]    status_im,
    input  logic [IRQ_W-1:0]    irq_i,
    output logic                exception,
    output logic                eret,
    output logic [4:0]          ex_type,
    output logic [31:0]         epc,
    output logic                flush,
    output logic                in_handler,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic                fault_err,
    output exc_state_e          dbg_state
`ifdef EXC_STATS_EN
    ,
    output logic [31:0]         exc_count,
    output logic [31:0]         irq_count
`endif
);

    // ------------------------------------------------------------------
    // IRQ synchronizers and edge detectors
    // ------------------------------------------------------------------
    logic [IRQ_W-1:0] rise;

    for (genvar g = 0; g < IRQ_W; g++) begin : g_irq
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .irq_async(irq_i[g]),
            .rise     (rise[g])
        );
    end

    // ------------------------------------------------------------------
    // Pending / arbitration
    // ------------------------------------------------------------------
    exc_state_e            state_q;
    exc_state_e            state_d;
    logic [IRQ_W-1:0]      pending_q;
    logic [IRQ_W-1:0]      pending_d;
    logic [IRQ_W-1:0]      eligible;
    logic [IRQ_W-1:0]      clr_mask;
    logic [IRQ_ID_W-1:0]   irq_sel;
    logic                  sync_evt;
    logic                  take_sync;
    logic                  take_irq;
    logic                  fault_set;
    logic [4:0]            sync_code;

    assign sync_evt = trap_i | syscall_i | break_i;
    assign eligible = pending_q & status_im;
    assign irq_sel  = lowest_set(8'(eligible));

    // trap > syscall > break
    always_comb begin
        sync_code = EXC_BP;
        if (trap_i) begin
            sync_code = EXC_TR;
        end else if (syscall_i) begin
            sync_code = EXC_SYS;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        take_sync = 1'b0;
        take_irq  = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            IDLE: begin
                // Synchronous events pre-empt interrupts; the IRQ stays pending.
                if (sync_evt) begin
                    state_d   = ENTER;
                    take_sync = 1'b1;
                end else if (status_ie && (|eligible)) begin
                    state_d   = ENTER;
                    take_irq  = 1'b1;
                end
                if (eret_i) begin
                    fault_set = 1'b1;
                end
            end
            ENTER: begin
                state_d = HANDLER;
            end
            HANDLER: begin
                if (eret_i) begin
                    state_d = RETURN;
                end
                // Nested synchronous exceptions are not supported: flag and drop.
                if (sync_evt) begin
                    fault_set = 1'b1;
                end
            end
            RETURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Only the serviced line is cleared; a fresh edge on that same line in
    // the same cycle re-sets it because the OR with rise comes last.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < IRQ_W; i++) begin
            clr_mask[i] = take_irq && (irq_sel == IRQ_ID_W'(i));
        end
    end

    assign pending_d = (pending_q & ~clr_mask) | rise;

    // ------------------------------------------------------------------
    // State, pending and registered outputs
    // ------------------------------------------------------------------
    // Strobes are registered from the next state, so the cycle that follows
    // the sampling edge is exactly the ENTER/RETURN cycle. Because ENTER is
    // always followed by HANDLER and RETURN by IDLE, a strobe can never last
    // two consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            exception  <= 1'b0;
            eret       <= 1'b0;
            flush      <= 1'b0;
            in_handler <= 1'b0;
            ex_type    <= '0;
            epc        <= '0;
            irq_id     <= '0;
            fault_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            exception  <= (state_d == ENTER) || (state_d == RETURN);
            eret       <= (state_d == RETURN);
            flush      <= (state_d == ENTER) || (state_d == RETURN);
            in_handler <= (state_d == HANDLER);
            if (take_sync) begin
                ex_type <= sync_code;
                epc     <= pc_i;
            end else if (take_irq) begin
                ex_type <= EXC_INT;
                // Interrupted instruction resumes after pc_i; wraps modulo 2^32.
                epc     <= pc_i + 32'd4;
                irq_id  <= irq_sel;
            end
            if (fault_set) begin
                fault_err <= 1'b1;
            end
        end
    end

    assign dbg_state = state_q;

`ifdef EXC_STATS_EN
    // ------------------------------------------------------------------
    // Saturating entry counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_count <= '0;
            irq_count <= '0;
        end else begin
            if ((take_sync || take_irq) && (exc_count != 32'hFFFF_FFFF)) begin
                exc_count <= exc_count + 32'd1;
            end
            if (take_irq && (irq_count != 32'hFFFF_FFFF)) begin
                irq_count <= irq_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exception_unit.sv
// -----------------------------------------------------------------------------
// tb_exception_unit
//   Directed vector table, hand-written reset/fault sequences, and a random
//   phase scored against a behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_exception_unit;
  import exc_pkg::*;

  localparam int IRQ_W = 6;
  localparam int SYNC  = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]      pc_i;
  logic             syscall_i, break_i, trap_i, eret_i, status_ie;
  logic [IRQ_W-1:0] status_im, irq_i;
  logic             exception, eret, flush, in_handler, fault_err;
  logic [4:0]       ex_type;
  logic [31:0]      epc;
  logic [2:0]       irq_id;
  exc_state_e       dbg_state;

  exception_unit #(.IRQ_W(IRQ_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i),
    .syscall_i(syscall_i), .break_i(break_i), .trap_i(trap_i), .eret_i(eret_i),
    .status_ie(status_ie), .status_im(status_im), .irq_i(irq_i),
    .exception(exception), .eret(eret), .ex_type(ex_type), .epc(epc),
    .flush(flush), .in_handler(in_handler), .irq_id(irq_id),
    .fault_err(fault_err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // {exception, eret, flush, in_handler, ex_type, epc, irq_id, fault_err}
  function automatic logic [44:0] dut_out();
    return {exception, eret, flush, in_handler, ex_type, epc, irq_id, fault_err};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    pc_i = '0; syscall_i = 0; break_i = 0; trap_i = 0; eret_i = 0;
    status_ie = 0; status_im = '0; irq_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (one row = one clock cycle)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  ev;   // {syscall, break, trap, eret}
    logic        ie;
    logic [5:0]  im;
    logic [5:0]  irq;
    logic [31:0] pc;
    logic [44:0] exp;
  } row_t;

  localparam logic [3:0] N = 4'b0000, SYS = 4'b1000, BRK = 4'b0100, TRP = 4'b0010, ERT = 4'b0001;
  // {exception, eret, flush, in_handler}
  localparam logic [3:0] Z = 4'b0000, ENT = 4'b1010, RET = 4'b1110, HND = 4'b0001;

  function automatic row_t mk(input logic [3:0] ev, input logic ie, input logic [5:0] im,
                              input logic [5:0] irq, input logic [31:0] pc, input logic [3:0] fl,
                              input logic [4:0] ty, input logic [31:0] e_epc,
                              input logic [2:0] id, input logic flt);
    row_t r;
    r.ev = ev; r.ie = ie; r.im = im; r.irq = irq; r.pc = pc;
    r.exp = {fl, ty, e_epc, id, flt};
    return r;
  endfunction

  row_t tbl[$];

  task automatic build_table();
    // syscall entry and return
    tbl.push_back(mk(N,   0, 6'h00, 6'h00, 32'h000, Z,   0,  32'h000, 0, 0));
    tbl.push_back(mk(SYS, 0, 6'h00, 6'h00, 32'h100, ENT, 8,  32'h100, 0, 0));
    tbl.push_back(mk(N,   0, 6'h00, 6'h00, 32'h100, HND, 8,  32'h100, 0, 0));
    tbl.push_back(mk(ERT, 0, 6'h00, 6'h00, 32'h100, RET, 8,  32'h100, 0, 0));
    tbl.push_back(mk(N,   0, 6'h00, 6'h00, 32'h100, Z,   8,  32'h100, 0, 0));
    // irq[2] and irq[4] rise together: 2 first, then 4 after ERET
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(N, 1, 6'h3F, 6'h14, 32'h200, Z,   8,  32'h100, 0, 0));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h14, 32'h200, ENT, 0,  32'h204, 2, 0));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h14, 32'h200, HND, 0,  32'h204, 2, 0));
    tbl.push_back(mk(ERT, 1, 6'h3F, 6'h14, 32'h200, RET, 0,  32'h204, 2, 0));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h14, 32'h200, Z,   0,  32'h204, 2, 0));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h14, 32'h200, ENT, 0,  32'h204, 4, 0));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h14, 32'h200, HND, 0,  32'h204, 4, 0));
    tbl.push_back(mk(ERT, 1, 6'h3F, 6'h14, 32'h200, RET, 0,  32'h204, 4, 0));
    // irq[1] pending, then trap+break in the same cycle: trap wins
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(N, 1, 6'h3F, 6'h16, 32'h300, Z,   0,  32'h204, 4, 0));
    tbl.push_back(mk(TRP | BRK, 1, 6'h3F, 6'h16, 32'h300, ENT, 13, 32'h300, 4, 0));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h16, 32'h300, HND, 13, 32'h300, 4, 0));
    tbl.push_back(mk(ERT, 1, 6'h3F, 6'h16, 32'h300, RET, 13, 32'h300, 4, 0));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h16, 32'h300, Z,   13, 32'h300, 4, 0));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h16, 32'h300, ENT, 0,  32'h304, 1, 0));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h16, 32'h300, HND, 0,  32'h304, 1, 0));
    // break inside the handler: fault, dropped
    tbl.push_back(mk(BRK, 1, 6'h3F, 6'h16, 32'h300, HND, 0,  32'h304, 1, 1));
    tbl.push_back(mk(ERT, 1, 6'h3F, 6'h16, 32'h300, RET, 0,  32'h304, 1, 1));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h16, 32'h300, Z,   0,  32'h304, 1, 1));
    // irq[0] pending with IE=0: held off until IE rises
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(N, 0, 6'h3F, 6'h17, 32'h400, Z,   0,  32'h304, 1, 1));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h17, 32'h400, ENT, 0,  32'h404, 0, 1));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h17, 32'h400, HND, 0,  32'h404, 0, 1));
    tbl.push_back(mk(ERT, 1, 6'h3F, 6'h17, 32'h400, RET, 0,  32'h404, 0, 1));
    // irq[3] at pc 0xFFFFFFFC: epc wraps to 0
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(N, 1, 6'h3F, 6'h1F, 32'hFFFF_FFFC, Z, 0, 32'h404, 0, 1));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h1F, 32'hFFFF_FFFC, ENT, 0, 32'h0, 3, 1));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h1F, 32'hFFFF_FFFC, HND, 0, 32'h0, 3, 1));
    tbl.push_back(mk(ERT, 1, 6'h3F, 6'h1F, 32'hFFFF_FFFC, RET, 0, 32'h0, 3, 1));
    tbl.push_back(mk(N,   1, 6'h3F, 6'h1F, 32'hFFFF_FFFC, Z,   0, 32'h0, 3, 1));
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one call per clock edge, using the inputs about to be
  // sampled. Mode: 0 idle, 1 entry strobe, 2 handler, 3 return strobe.
  // ---------------------------------------------------------------------------
  int          m_mode;
  logic [5:0]  m_pend;
  logic [5:0]  m_hist[$];   // irq_i samples, [0] = most recent edge
  logic [4:0]  m_ty;
  logic [31:0] m_epc;
  logic [2:0]  m_id;
  logic        m_flt;

  task automatic model_reset();
    m_mode = 0; m_pend = '0; m_ty = '0; m_epc = '0; m_id = '0; m_flt = 1'b0;
    m_hist.delete();
    for (int i = 0; i <= SYNC; i++) m_hist.push_back('0);
  endtask

  task automatic model_step();
    logic [5:0] new_edge, elig;
    bit         found;
    int         nxt;
    // A line becomes pending SYNC+1 edges after the raw rise was first sampled.
    new_edge = m_hist[SYNC-1] & ~m_hist[SYNC];
    elig     = m_pend & status_im;
    nxt      = m_mode;
    if (m_mode == 0) begin
      if (trap_i || syscall_i || break_i) begin
        nxt   = 1;
        m_ty  = trap_i ? 5'd13 : (syscall_i ? 5'd8 : 5'd9);
        m_epc = pc_i;
      end else if (status_ie && elig != 0) begin
        found = 0;
        for (int i = 0; i < 6; i++) begin
          if (!found && elig[i]) begin
            found = 1;
            m_id  = 3'(i);
          end
        end
        m_pend[m_id] = 1'b0;
        nxt   = 1;
        m_ty  = 5'd0;
        m_epc = pc_i + 32'd4;
      end
      if (eret_i) m_flt = 1'b1;
    end else if (m_mode == 1) begin
      nxt = 2;
    end else if (m_mode == 2) begin
      if (eret_i) nxt = 3;
      if (trap_i || syscall_i || break_i) m_flt = 1'b1;
    end else begin
      nxt = 0;
    end
    m_pend = m_pend | new_edge;
    m_hist.push_front(irq_i);
    void'(m_hist.pop_back());
    m_mode = nxt;
  endtask

  function automatic logic [44:0] model_out();
    logic strobe;
    strobe = (m_mode == 1) || (m_mode == 3);
    return {strobe, m_mode == 3, strobe, m_mode == 2, m_ty, m_epc, m_id, m_flt};
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [44:0] exp_q[$];

  initial begin
    clear_inputs();
    build_table();

    // Reset state
    do_reset();
    check("reset_outputs", 64'(dut_out()), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));

    // Directed table
    foreach (tbl[i]) begin
      {syscall_i, break_i, trap_i, eret_i} = tbl[i].ev;
      status_ie = tbl[i].ie;
      status_im = tbl[i].im;
      irq_i     = tbl[i].irq;
      pc_i      = tbl[i].pc;
      step();
      check($sformatf("row%0d", i), 64'(dut_out()), 64'(tbl[i].exp));
    end
    check("table_end_state", 64'(dbg_state), 64'(IDLE));

    // ERET in IDLE: fault, no strobe, sticky
    do_reset();
    eret_i = 1;
    step();
    eret_i = 0;
    check("eret_idle_strobe", 64'({exception, eret, flush}), 64'd0);
    check("eret_idle_fault", 64'(fault_err), 64'd1);
    step();
    check("fault_sticky", 64'(fault_err), 64'd1);

    // Reset in the middle of a handler clears everything at once
    do_reset();
    syscall_i = 1; pc_i = 32'h40;
    step();
    syscall_i = 0;
    check("mid_enter", 64'({exception, ex_type}), 64'({1'b1, 5'd8}));
    step();
    check("mid_handler", 64'(dbg_state), 64'(HANDLER));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'(dut_out()), 64'd0);
    check("async_reset_state", 64'(dbg_state), 64'(IDLE));

    // Randomized phase against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      syscall_i = ($urandom_range(15) == 0);
      break_i   = ($urandom_range(15) == 0);
      trap_i    = ($urandom_range(15) == 0);
      eret_i    = ($urandom_range(3) == 0);
      status_ie = ($urandom_range(7) != 0);
      if ($urandom_range(7) == 0) status_im = 6'($urandom_range(63));
      for (int b = 0; b < IRQ_W; b++)
        if ($urandom_range(7) == 0) irq_i[b] = ~irq_i[b];
      pc_i = ($urandom_range(31) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC;
      model_step();
      exp_q.push_back(model_out());
      step();
      check($sformatf("rand%0d", c), 64'(dut_out()), 64'(exp_q.pop_front()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Exception/interrupt sequencer directly upstream of the CP0 register file.
- Collects synchronous exception requests from decode (syscall, break, teq trap), ERET, and asynchronous external IRQ lines.
- Arbitrates these requests and drives CP0 with registered one-cycle strobes: exception, eret, ex_type, epc.
- Issues a pipeline flush to the PC/fetch logic; the redirect target is read from CP0's output.

Parameters:
- IRQ_W, 6, number of external interrupt lines. Must be 1..8.
- SYNC_STAGES, 2, flip-flop synchronizer depth per IRQ line. Must be ≥2.

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_i  in  32  PC of the instruction currently in decode.
- syscall_i  in  1  decoded SYSCALL.
- break_i  in  1  decoded BREAK.
- trap_i  in  1  TEQ condition true.
- eret_i  in  1  decoded ERET.
- status_ie  in  1  Status.IE from CP0.
- status_im  in  IRQ_W  Status interrupt-mask bits from CP0.
- irq_i  in  IRQ_W  asynchronous external interrupt lines, level-high.
- exception  out  1  CP0 exception strobe.
- eret  out  1  CP0 eret qualifier, valid with exception.
- ex_type  out  5  CP0 cause code: Int=0, Sys=8, Bp=9, Tr=13.
- epc  out  32  PC handed to CP0.
- flush  out  1  squash decode/fetch and take the CP0 redirect.
- in_handler  out  1  handler active.
- irq_id  out  3  index of the serviced IRQ.
- fault_err  out  1  sticky: illegal event seen (see Behaviour).

Behaviour:
- Reset (async): all outputs 0, state IDLE, pending and synchronizer flops cleared.
- Reset asserted mid-handler aborts to IDLE; no strobe is emitted.
- IRQ path:
  - Each irq_i bit passes through SYNC_STAGES flops.
  - A rising edge of the synchronized level sets pending[i].
  - Pending bits stay set until serviced or reset.
- FSM states and transitions:
  - IDLE:
    - Any of syscall/break/trap → ENTER.
    - Priority: trap > syscall > break. ex_type = 13, 8 or 9 respectively.
    - For these synchronous events, epc = pc_i.
    - Else if status_ie && |(pending & status_im) → ENTER with ex_type = 0.
    - The serviced IRQ is the lowest set index of (pending & status_im). irq_id = that index; only that pending bit is cleared.
    - For interrupts, epc = pc_i + 4.
    - eret_i in IDLE → sets fault_err, no strobe.
  - ENTER (1 cycle):
    - exception = 1, eret = 0, flush = 1.
    - Next state: HANDLER.
  - HANDLER:
    - in_handler = 1; interrupts are not taken.
    - eret_i → RETURN.
    - syscall/break/trap while in HANDLER → sets fault_err; the event is dropped.
  - RETURN (1 cycle):
    - exception = 1, eret = 1, flush = 1, ex_type holds its last value.
    - Next state: IDLE.
- Latency: an event sampled at posedge N yields its strobe during cycle N+1. CP0 captures on the negedge of that cycle.
- An IRQ arriving on irq_i needs SYNC_STAGES+1 edges before it is pending, and one more edge to enter.
- Simultaneous events:
  - A synchronous event and an eligible IRQ in the same cycle: the synchronous event wins and the IRQ stays pending.
  - An IRQ edge in the same cycle its own pending bit is cleared: the set wins.
- exception, eret and flush are never high for 2 consecutive cycles.
- epc arithmetic is 32-bit modulo, so 0xFFFFFFFC + 4 = 0.
- fault_err clears only on reset.

Optional Feature:
- Macro: EXC_STATS_EN.
- With it defined:
  - Adds outputs exc_count[31:0] and irq_count[31:0].
  - exc_count increments on every ENTER; irq_count increments on ENTER with ex_type = 0.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Without it, neither port nor counter logic exists.

Decomposition:
- Package exc_pkg holds:
  - ex_type codes EXC_INT, EXC_SYS, EXC_BP, EXC_TR;
  - the FSM state enum (IDLE, ENTER, HANDLER, RETURN);
  - IRQ_ID_W = 3.
- One sub-module, irq_sync_edge: a per-line synchronizer plus rising-edge detector, instantiated IRQ_W times via generate.

Test Plan:
- Reset, then syscall_i = 1 with pc_i = 0x100 for 1 cycle → next cycle exception = 1, ex_type = 8, epc = 0x100, flush = 1; in_handler = 1 afterwards.
- In HANDLER, eret_i pulse → next cycle exception = 1, eret = 1; then in_handler = 0 and the FSM is in IDLE.
- status_ie = 1, status_im = 0x3F, irq_i[2] and irq_i[4] rise together, pc_i = 0x200 → strobe with ex_type = 0, irq_id = 2, epc = 0x204. After ERET, irq_id = 4 is serviced next.
- trap_i, break_i and an eligible IRQ asserted in the same cycle → ex_type = 13; the IRQ is still pending and is taken after ERET.
- break_i in HANDLER, and eret_i in IDLE → fault_err = 1, no strobe; rst_n low mid-HANDLER → all outputs 0 immediately.
- status_ie = 0 with an IRQ pending → no strobe. Raise status_ie → strobe on the following cycle.
